// File: rtl/switch_allocator_3p.sv
`default_nettype none
// ============================================================================
//  Module      : switch_allocator_3p
//  Description : Wormhole switch allocator for a 3-port mesh router. Each
//                output runs a round-robin arbiter over header flits and then
//                stays locked to the winning input until the packet tail has
//                been forwarded. Grants (rd_en/sel/out_valid) are
//                combinational from the inputs and the registered state.
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_allocator_3p #(
    parameter int NPORT = 3,
    parameter int LEN_W = 12
) (
    input  logic                     clk,
    input  logic                     rst,        // asynchronous, active-low
    input  logic [NPORT-1:0]         req_valid,
    input  logic [NPORT*NPORT-1:0]   req_port,
    input  logic [NPORT-1:0]         req_head,
    input  logic [NPORT*LEN_W-1:0]   req_len,
    input  logic [NPORT-1:0]         out_ready,
    output logic [NPORT-1:0]         rd_en,
    output logic [NPORT*NPORT-1:0]   sel,
    output logic [NPORT-1:0]         out_valid,
    output logic [NPORT-1:0]         busy
);

    localparam int               IDX_W   = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam logic [NPORT-1:0] ONE_N   = NPORT'(1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           r_state  [NPORT];
    logic [IDX_W-1:0] r_owner  [NPORT];
    logic [IDX_W-1:0] r_ptr    [NPORT];
    logic [LEN_W-1:0] r_remain [NPORT];

    logic [NPORT-1:0] w_mask;              // inputs that currently own an output
    logic [NPORT-1:0] w_port_lsb [NPORT];  // lowest requested output per input
    logic [NPORT-1:0] w_grant    [NPORT];  // one-hot input granted by output j
    logic [NPORT-1:0] w_hdr_win;           // output j grants a header this cycle
    logic [NPORT-1:0] w_fwd;               // output j forwards a body/tail flit
    logic [IDX_W-1:0] w_win_idx  [NPORT];
    logic [IDX_W-1:0] w_ptr_nxt  [NPORT];
    logic [LEN_W-1:0] w_win_len  [NPORT];

    // Owner mask and lowest-set-bit reduction of each input's output request
    always_comb begin
        w_mask = '0;
        for (int k = 0; k < NPORT; k++) begin
            if (r_state[k] == ST_LOCKED) begin
                w_mask[r_owner[k]] = 1'b1;
            end
        end
        for (int i = 0; i < NPORT; i++) begin
            w_port_lsb[i] = req_port[i*NPORT +: NPORT]
                          & (~req_port[i*NPORT +: NPORT] + ONE_N);
        end
    end

    // Per-output round-robin header arbitration and locked-packet forwarding
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        int               idx;
        found = 1'b0;
        cand  = '0;
        idx   = 0;
        for (int j = 0; j < NPORT; j++) begin
            w_grant[j]   = '0;
            w_hdr_win[j] = 1'b0;
            w_fwd[j]     = 1'b0;
            w_win_idx[j] = '0;
            w_ptr_nxt[j] = '0;
            w_win_len[j] = '0;
            found        = 1'b0;
            if (r_state[j] == ST_IDLE) begin
                for (int off = 0; off < NPORT; off++) begin
                    idx = int'(r_ptr[j]) + off;
                    if (idx >= NPORT) begin
                        idx = idx - NPORT;
                    end
                    cand = IDX_W'(idx);
                    if (!found && req_valid[cand] && req_head[cand] &&
                        w_port_lsb[cand][j] && !w_mask[cand]) begin
                        found        = 1'b1;
                        w_win_idx[j] = cand;
                    end
                end
                if (found && out_ready[j]) begin
                    w_hdr_win[j] = 1'b1;
                    w_grant[j]   = ONE_N << w_win_idx[j];
                    w_win_len[j] = req_len[w_win_idx[j]*LEN_W +: LEN_W];
                    w_ptr_nxt[j] = (int'(w_win_idx[j]) == NPORT-1) ? '0
                                                                  : w_win_idx[j] + IDX_ONE;
                end
            end else begin
                // Owner's flits are all treated as body while locked
                if (req_valid[r_owner[j]] && out_ready[j]) begin
                    w_fwd[j]   = 1'b1;
                    w_grant[j] = ONE_N << r_owner[j];
                end
            end
        end
    end

    // Output drive; everything is forced quiet while reset is held
    always_comb begin
        rd_en     = '0;
        sel       = '0;
        out_valid = '0;
        busy      = '0;
        for (int j = 0; j < NPORT; j++) begin
            busy[j] = (r_state[j] == ST_LOCKED);
            if (rst) begin
                rd_en        = rd_en | w_grant[j];
                out_valid[j] = |w_grant[j];
                sel[j*NPORT +: NPORT] = (r_state[j] == ST_LOCKED) ? (ONE_N << r_owner[j])
                                                                  : w_grant[j];
            end
        end
    end

    // Per-output lock FSM: IDLE -> LOCKED on multi-flit header, back on tail
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < NPORT; j++) begin
                r_state[j]  <= ST_IDLE;
                r_owner[j]  <= '0;
                r_ptr[j]    <= '0;
                r_remain[j] <= '0;
            end
        end else begin
            for (int j = 0; j < NPORT; j++) begin
                case (r_state[j])
                    ST_IDLE: begin
                        if (w_hdr_win[j]) begin
                            r_ptr[j] <= w_ptr_nxt[j];
                            if (w_win_len[j] != '0) begin
                                r_owner[j]  <= w_win_idx[j];
                                r_remain[j] <= w_win_len[j];
                                r_state[j]  <= ST_LOCKED;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (w_fwd[j]) begin
                            // Saturating count-down: tail flit releases the lock
                            if (r_remain[j] <= LEN_ONE) begin
                                r_remain[j] <= '0;
                                r_state[j]  <= ST_IDLE;
                            end else begin
                                r_remain[j] <= r_remain[j] - LEN_ONE;
                            end
                        end
                    end
                    default: r_state[j] <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
